// File: rtl/shift_iter_unit.sv
// Iterative barrel-less shifter: applies one 1-bit shift/rotate step per cycle
// until the captured amount is exhausted, then pulses done for one cycle.
module shift_iter_unit #(
  parameter int DATA_W = 32,
  parameter int AMT_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [1:0]        amt_sel,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] reg_b_info,
  input  logic [15:0]       imediato,
  input  logic [DATA_W-1:0] mdr_out,
  output logic [DATA_W-1:0] result,
  output logic              busy,
  output logic              done,
  output logic [AMT_W-1:0]  amt_latched
);

  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_SRL = 3'b010;
  localparam logic [2:0] OP_SRA = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b100;
  localparam logic [2:0] OP_ROR = 3'b101;

  typedef enum logic [1:0] {
    SHIFT_IDLE,
    SHIFT_RUN,
    SHIFT_DONE
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [2:0]        op_q;
  logic [AMT_W-1:0]  cnt;
  logic [AMT_W-1:0]  sel_amt;
  logic              is_shift;
  logic [DATA_W-1:0] step_val;
  logic              unused_bits;

  // Upper operand bits never feed the amount; truncation gives the modulo-DATA_W wrap.
  assign unused_bits = ^{reg_b_info[DATA_W-1:AMT_W], imediato[15:6+AMT_W],
                         imediato[5:0], mdr_out[DATA_W-1:AMT_W]};

  always_comb begin
    sel_amt = '0;
    case (amt_sel)
      2'b00:   sel_amt = reg_b_info[AMT_W-1:0];
      2'b01:   sel_amt = imediato[6+AMT_W-1:6];
      2'b10:   sel_amt = mdr_out[AMT_W-1:0];
      default: sel_amt = AMT_W'(1);
    endcase
  end

  assign is_shift = (op >= OP_SLL) && (op <= OP_ROR);

  always_comb begin
    step_val = result;
    case (op_q)
      OP_SLL:  step_val = {result[DATA_W-2:0], 1'b0};
      OP_SRL:  step_val = {1'b0, result[DATA_W-1:1]};
      OP_SRA:  step_val = {result[DATA_W-1], result[DATA_W-1:1]};
      OP_ROL:  step_val = {result[DATA_W-2:0], result[DATA_W-1]};
      OP_ROR:  step_val = {result[0], result[DATA_W-1:1]};
      default: step_val = result;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SHIFT_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      SHIFT_IDLE: begin
        if (start) begin
          next_state = ((sel_amt != '0) && is_shift) ? SHIFT_RUN : SHIFT_DONE;
        end
      end
      SHIFT_RUN: begin
        busy = 1'b1;
        if (cnt <= AMT_W'(1)) begin
          next_state = SHIFT_DONE;
        end
      end
      SHIFT_DONE: begin
        done       = 1'b1;
        next_state = SHIFT_IDLE;
      end
      default: next_state = SHIFT_IDLE;
    endcase
  end

  // Operands are captured only on an accepted start; result holds after DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      result      <= '0;
      amt_latched <= '0;
      cnt         <= '0;
      op_q        <= '0;
    end else begin
      case (state)
        SHIFT_IDLE: begin
          if (start) begin
            result      <= data_in;
            op_q        <= op;
            amt_latched <= sel_amt;
            cnt         <= sel_amt;
          end
        end
        SHIFT_RUN: begin
          result <= step_val;
          cnt    <= cnt - AMT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_iter_unit.sv
// Self-checking bench for shift_iter_unit: table vectors, random vectors and
// hand-written sequences, all checked through a queue-based scoreboard.
module tb_shift_iter_unit;

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  amt_sel;
    logic [31:0] data;
    logic [31:0] regb;
    logic [15:0] imm;
    logic [31:0] mdr;
    logic [31:0] exp_res;
    logic [4:0]  exp_amt;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  amt;
    int          lat;
    int          start_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [1:0]  amt_sel;
  logic [31:0] data_in;
  logic [31:0] reg_b_info;
  logic [15:0] imediato;
  logic [31:0] mdr_out;
  logic [31:0] result;
  logic        busy;
  logic        done;
  logic [4:0]  amt_latched;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   busy_cnt = 0;
  exp_t sb[$];
  vec_t tbl[12];

  shift_iter_unit #(.DATA_W(32), .AMT_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .amt_sel(amt_sel),
    .data_in(data_in), .reg_b_info(reg_b_info), .imediato(imediato),
    .mdr_out(mdr_out), .result(result), .busy(busy), .done(done),
    .amt_latched(amt_latched)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void checkOutput(string name, logic [63:0] actual, logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endfunction

  function automatic logic [31:0] model(logic [2:0] mop, logic [31:0] d, int n);
    case (mop)
      3'd1:    return d << n;
      3'd2:    return d >> n;
      3'd3:    return 32'($signed(d) >>> n);
      3'd4:    return (n == 0) ? d : ((d << n) | (d >> (32 - n)));
      3'd5:    return (n == 0) ? d : ((d >> n) | (d << (32 - n)));
      default: return d;
    endcase
  endfunction

  function automatic vec_t mk(logic [2:0] mop, logic [1:0] sel, logic [31:0] d, logic [31:0] rb,
                              logic [15:0] im, logic [31:0] md, logic [31:0] er, logic [4:0] ea, int el);
    vec_t v;
    v.op = mop; v.amt_sel = sel; v.data = d; v.regb = rb; v.imm = im; v.mdr = md;
    v.exp_res = er; v.exp_amt = ea; v.exp_lat = el;
    return v;
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_done", 64'(done), 64'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("result", 64'(result), 64'(e.res));
          checkOutput("amt_latched", 64'(amt_latched), 64'(e.amt));
          checkOutput("latency", 64'(cyc - e.start_cyc), 64'(e.lat));
          checkOutput("busy_cycles", 64'(busy_cnt), 64'(e.lat - 1));
          checkOutput("busy_with_done", 64'(busy), 64'd0);
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("drain_left", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  task automatic scramble();
    op         = 3'($urandom);
    amt_sel    = 2'($urandom);
    data_in    = $urandom;
    reg_b_info = $urandom;
    imediato   = 16'($urandom);
    mdr_out    = $urandom;
  endtask

  // Called right at a falling edge with the DUT idle.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    op = v.op; amt_sel = v.amt_sel; data_in = v.data;
    reg_b_info = v.regb; imediato = v.imm; mdr_out = v.mdr;
    start = 1'b1;
    e.res = v.exp_res; e.amt = v.exp_amt; e.lat = v.exp_lat; e.start_cyc = cyc;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    scramble();
    #1;
    drain();
    @(negedge clk);
    checkOutput("hold_result", 64'(result), 64'(v.exp_res));
    checkOutput("hold_amt", 64'(amt_latched), 64'(v.exp_amt));
    checkOutput("post_done", 64'(done), 64'd0);
  endtask

  initial begin
    vec_t v;
    exp_t e;
    int   n;
    int   k;

    tbl[0]  = mk(3'd1, 2'd1, 32'h0000_0001, 32'h1234_5677, 16'h0100, 32'h0000_0007, 32'h0000_0010, 5'd4, 5);
    tbl[1]  = mk(3'd3, 2'd0, 32'h8000_0000, 32'hFFFF_FFE3, 16'hFFFF, 32'h0000_0011, 32'hF000_0000, 5'd3, 4);
    tbl[2]  = mk(3'd5, 2'd2, 32'h0000_0001, 32'h0000_001F, 16'h07C0, 32'h0000_0021, 32'h8000_0000, 5'd1, 2);
    tbl[3]  = mk(3'd2, 2'd0, 32'h1234_5678, 32'h0000_0020, 16'h0140, 32'h0000_0005, 32'h1234_5678, 5'd0, 1);
    tbl[4]  = mk(3'd4, 2'd3, 32'h8000_0001, 32'h0000_0000, 16'h0000, 32'h0000_0000, 32'h0000_0003, 5'd1, 2);
    tbl[5]  = mk(3'd0, 2'd3, 32'hDEAD_BEEF, 32'h0000_0009, 16'h0200, 32'h0000_0003, 32'hDEAD_BEEF, 5'd1, 1);
    tbl[6]  = mk(3'd6, 2'd1, 32'hCAFE_F00D, 32'h0000_0002, 16'h07C0, 32'h0000_0004, 32'hCAFE_F00D, 5'd31, 1);
    tbl[7]  = mk(3'd2, 2'd2, 32'h8000_0000, 32'h0000_0003, 16'h0080, 32'h0000_001F, 32'h0000_0001, 5'd31, 32);
    tbl[8]  = mk(3'd3, 2'd0, 32'h7000_0000, 32'h0000_0004, 16'h0040, 32'h0000_0002, 32'h0700_0000, 5'd4, 5);
    tbl[9]  = mk(3'd4, 2'd1, 32'h1234_5678, 32'h0000_0001, 16'h0200, 32'h0000_0001, 32'h3456_7812, 5'd8, 9);
    tbl[10] = mk(3'd5, 2'd0, 32'h1234_5678, 32'h0000_0004, 16'h0000, 32'h0000_0009, 32'h8123_4567, 5'd4, 5);
    tbl[11] = mk(3'd1, 2'd2, 32'hFFFF_FFFF, 32'h0000_0006, 16'h0040, 32'h0000_003F, 32'h8000_0000, 5'd31, 32);

    reset = 1'b1;
    start = 1'b0;
    op = '0; amt_sel = '0; data_in = '0; reg_b_info = '0; imediato = '0; mdr_out = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_result", 64'(result), 64'd0);
    checkOutput("reset_amt", 64'(amt_latched), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);

    // First start goes in the very cycle reset is released.
    reset = 1'b0;
    foreach (tbl[i]) applyStimulus(tbl[i]);

    // start held high across a long SLL: only re-accepted once back in IDLE.
    op = 3'd1; amt_sel = 2'd2; mdr_out = 32'd31; data_in = 32'h1; start = 1'b1;
    e.res = 32'h8000_0000; e.amt = 5'd31; e.lat = 32; e.start_cyc = cyc;
    sb.push_back(e);
    @(negedge clk);
    data_in = 32'hFFFF_0000; mdr_out = 32'd5; op = 3'd2;
    #1;
    drain();
    @(negedge clk);
    checkOutput("held_start_busy", 64'(busy), 64'd0);
    checkOutput("held_start_done", 64'(done), 64'd0);
    op = 3'd1; data_in = 32'h3; mdr_out = 32'd2;
    e.res = 32'h0000_000C; e.amt = 5'd2; e.lat = 3; e.start_cyc = cyc;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    #1;
    drain();
    @(negedge clk);

    // Reset in the middle of a 10-step SRL discards the partial result.
    op = 3'd2; amt_sel = 2'd0; reg_b_info = 32'd10; data_in = 32'hFFFF_FFFF; start = 1'b1;
    k = cyc;
    @(negedge clk);
    start = 1'b0;
    while (cyc < k + 3) @(negedge clk);
    checkOutput("midrun_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_result", 64'(result), 64'd0);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_done", 64'(done), 64'd0);
    checkOutput("abort_amt", 64'(amt_latched), 64'd0);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    checkOutput("abort_idle_result", 64'(result), 64'd0);
    checkOutput("abort_idle_busy", 64'(busy), 64'd0);

    // Random vectors against a word-level model of the shift.
    for (int r = 0; r < 10; r++) begin
      v.op = 3'($urandom_range(0, 7));
      v.amt_sel = 2'($urandom_range(0, 3));
      v.data = $urandom;
      v.regb = $urandom;
      v.imm = 16'($urandom);
      v.mdr = $urandom;
      case (v.amt_sel)
        2'd0:    n = int'(v.regb % 32);
        2'd1:    n = int'((v.imm >> 6) % 32);
        2'd2:    n = int'(v.mdr % 32);
        default: n = 1;
      endcase
      v.exp_res = model(v.op, v.data, n);
      v.exp_amt = 5'(n);
      v.exp_lat = (n != 0 && v.op >= 3'd1 && v.op <= 3'd5) ? n + 1 : 1;
      applyStimulus(v);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
